// File: rtl/demux_capture_2_if.sv
// Bus bundle for demux_capture_2: the incoming demux lanes with their
// phase and handshake, and the assembled pair output with its handshake.
interface demux_capture_2_if #(
    parameter int WIDTH = 25
);
    logic [2*WIDTH-1:0] inp;
    logic               sel;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         pair_count;

    // Producer/consumer side that drives lanes and accepts pairs
    modport master (
        output inp, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, pair_count
    );

    // Capture block side
    modport slave (
        input  inp, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, pair_count
    );
endinterface

// File: rtl/demux_capture_2.sv
// Demux capture: picks the valid lane named by sel into one of two slots,
// and once both slots are filled hands the pair {slot1, slot0} downstream
// through a single-entry output register with valid/ready handshake.
module demux_capture_2 #(
    parameter int WIDTH          = 25,
    parameter int WIDTH_REGISTER = 5
) (
    input logic              clk,
    input logic              rst,
    demux_capture_2_if.slave dmx
);

    localparam int NUM_FIELDS = WIDTH / WIDTH_REGISTER;

    // Fill-mask states: bit0 = slot0 filled, bit1 = slot1 filled
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] HAVE0 = 2'b01;
    localparam logic [1:0] HAVE1 = 2'b10;
    localparam logic [1:0] PAIR  = 2'b11;

    logic [WIDTH-1:0]   slot0_q, slot0_d;
    logic [WIDTH-1:0]   slot1_q, slot1_d;
    logic [1:0]         mask_q, mask_d;
    logic [2*WIDTH-1:0] outData_q, outData_d;
    logic               outValid_q, outValid_d;
    logic [7:0]         pairCount_q, pairCount_d;

    logic [WIDTH-1:0]   lane0;
    logic [WIDTH-1:0]   lane1;
    logic               drain;
    logic               capture;
    logic               accept;
    logic               inReady;

    assign lane0 = dmx.inp[WIDTH-1:0];
    assign lane1 = dmx.inp[2*WIDTH-1:WIDTH];

    // A full pair moves out when the output register is free or emptying now
    assign drain   = (mask_q == PAIR) && (!outValid_q || dmx.out_ready);
    // A slot already holding data can be refilled only in the cycle it drains
    assign inReady = !mask_q[dmx.sel] || drain;
    assign capture = dmx.in_valid && inReady;
    assign accept  = outValid_q && dmx.out_ready;

    assign dmx.in_ready   = inReady;
    assign dmx.out_data   = outData_q;
    assign dmx.out_valid  = outValid_q;
    assign dmx.pair_count = pairCount_q;

    // Fill-mask transitions; captures may arrive in either order
    always_comb begin
        mask_d = mask_q;
        unique case (mask_q)
            EMPTY: begin
                if (capture) mask_d = dmx.sel ? HAVE1 : HAVE0;
            end
            HAVE0: begin
                if (capture && dmx.sel) mask_d = PAIR;
            end
            HAVE1: begin
                if (capture && !dmx.sel) mask_d = PAIR;
            end
            PAIR: begin
                if (drain) mask_d = capture ? (dmx.sel ? HAVE1 : HAVE0) : EMPTY;
            end
            default: mask_d = EMPTY;
        endcase
    end

    // Only the lane named by sel is written, into the matching slot
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (capture && !dmx.sel) slot0_d = lane0;
        if (capture && dmx.sel)  slot1_d = lane1;
    end

    // Assemble the pair field by field so each register lands at the same offset
    always_comb begin
        outData_d = outData_q;
        if (drain) begin
            for (int k = 0; k < NUM_FIELDS; k++) begin
                outData_d[k*WIDTH_REGISTER +: WIDTH_REGISTER] =
                    slot0_q[k*WIDTH_REGISTER +: WIDTH_REGISTER];
                outData_d[WIDTH + k*WIDTH_REGISTER +: WIDTH_REGISTER] =
                    slot1_q[k*WIDTH_REGISTER +: WIDTH_REGISTER];
            end
        end
    end

    // Output valid: set by a drain, cleared by a handshake with nothing replacing it
    always_comb begin
        outValid_d = outValid_q;
        if (drain) begin
            outValid_d = 1'b1;
        end else if (accept) begin
            outValid_d = 1'b0;
        end
    end

    // Handshake counter wraps naturally at 8 bits
    always_comb begin
        pairCount_d = pairCount_q;
        if (accept) pairCount_d = pairCount_q + 8'd1;
    end

    // State registers; reset discards any partial or pending pair
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q     <= '0;
            slot1_q     <= '0;
            mask_q      <= EMPTY;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            pairCount_q <= 8'd0;
        end else begin
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            mask_q      <= mask_d;
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            pairCount_q <= pairCount_d;
        end
    end

endmodule

// File: tb/tb_demux_capture_2.sv
// Testbench for demux_capture_2: directed vector table, hand-written
// backpressure / streaming / reset / wrap sequences, and random traffic,
// all compared against a slot-and-queue reference model.
module tb_demux_capture_2;

    localparam int W  = 25;
    localparam int WR = 5;

    typedef struct {
        bit           sel;
        bit           inValid;
        logic [W-1:0] lane0;
        logic [W-1:0] lane1;
        bit           outReady;
        bit           expInReady;
        bit           expOutValid;
        logic [2*W-1:0] expOutData;
        int           expCount;
    } vec_t;

    localparam logic [W-1:0] L0   = 25'b10000_01000_00100_00010_00001;
    localparam logic [W-1:0] L1   = 25'b11111_01111_00111_00011_00001;
    localparam logic [W-1:0] JUNK = 25'h15A5A5A;
    localparam logic [2*W-1:0] P  = {L1, L0};

    logic clk = 1'b0;
    logic rst;

    demux_capture_2_if #(.WIDTH(W)) dmx ();

    demux_capture_2 #(
        .WIDTH(W),
        .WIDTH_REGISTER(WR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dmx(dmx.slave)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: two slots with fill flags, a pending-output queue
    bit               mHave [2];
    logic [W-1:0]     mSlot [2];
    logic [2*W-1:0]   mPending [$];
    logic [2*W-1:0]   mShown;
    int               mCount;

    logic [2*W-1:0]   seen [$];

    bit               curRst, curSel, curValid, curReady;
    logic [W-1:0]     curL0, curL1;

    vec_t vecs [11];

    function automatic bit modelReady(bit s, bit ordy);
        bit pairGoes;
        pairGoes = mHave[0] && mHave[1] && (mPending.size() == 0 || ordy);
        return !mHave[s] || pairGoes;
    endfunction

    function automatic void modelStep(bit r, bit s, bit v, logic [W-1:0] l0,
                                      logic [W-1:0] l1, bit ordy);
        bit readyNow;
        bit pairGoes;
        logic [2*W-1:0] dropped;
        if (r) begin
            mHave[0] = 1'b0;
            mHave[1] = 1'b0;
            mSlot[0] = '0;
            mSlot[1] = '0;
            mPending.delete();
            mShown = '0;
            mCount = 0;
            return;
        end
        readyNow = modelReady(s, ordy);
        pairGoes = mHave[0] && mHave[1] && (mPending.size() == 0 || ordy);
        if (mPending.size() > 0 && ordy) begin
            dropped = mPending.pop_front();
            mCount = (mCount + 1) % 256;
        end
        if (pairGoes) begin
            mPending.push_back({mSlot[1], mSlot[0]});
            mShown = {mSlot[1], mSlot[0]};
            mHave[0] = 1'b0;
            mHave[1] = 1'b0;
        end
        if (v && readyNow) begin
            mSlot[s] = s ? l1 : l0;
            mHave[s] = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and move to the sampling point (negedge)
    task automatic applyStimulus(input bit r, input bit s, input bit v,
                                 input logic [W-1:0] l0, input logic [W-1:0] l1,
                                 input bit ordy);
        curRst = r; curSel = s; curValid = v; curL0 = l0; curL1 = l1; curReady = ordy;
        rst           = r;
        dmx.sel       = s;
        dmx.in_valid  = v;
        dmx.inp       = {l1, l0};
        dmx.out_ready = ordy;
        @(negedge clk);
    endtask

    // Compare against the model, log handshakes, advance past the next edge
    task automatic finishCycle();
        checkOutput("in_ready",   {63'd0, dmx.in_ready},  {63'd0, modelReady(curSel, curReady)});
        checkOutput("out_valid",  {63'd0, dmx.out_valid}, {63'd0, mPending.size() > 0});
        checkOutput("out_data",   {14'd0, dmx.out_data},  {14'd0, mShown});
        checkOutput("pair_count", {56'd0, dmx.pair_count}, 64'(mCount));
        if (!curRst && dmx.out_valid && curReady) seen.push_back(dmx.out_data);
        modelStep(curRst, curSel, curValid, curL0, curL1, curReady);
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input bit r, input bit s, input bit v,
                            input logic [W-1:0] l0, input logic [W-1:0] l1,
                            input bit ordy);
        applyStimulus(r, s, v, l0, l1, ordy);
        finishCycle();
    endtask

    function automatic logic [W-1:0] rndLane();
        return W'($urandom);
    endfunction

    initial begin
        logic [W-1:0] a0, a1, b0, b1, c0, c1;
        logic [W-1:0] cLane [2];
        int zeros;
        bit took;

        // Directed pair sequences: in-order pair, reverse pair, blocked slot
        vecs[0]  = '{0, 1, L0,   JUNK, 1, 1, 0, '0, 0};
        vecs[1]  = '{1, 1, JUNK, L1,   1, 1, 0, '0, 0};
        vecs[2]  = '{1, 0, JUNK, JUNK, 1, 1, 0, '0, 0};
        vecs[3]  = '{0, 0, JUNK, JUNK, 1, 1, 1, P,  0};
        vecs[4]  = '{1, 1, JUNK, L1,   1, 1, 0, P,  1};
        vecs[5]  = '{0, 1, L0,   JUNK, 1, 1, 0, P,  1};
        vecs[6]  = '{0, 0, JUNK, JUNK, 0, 1, 0, P,  1};
        vecs[7]  = '{0, 1, JUNK, JUNK, 0, 1, 1, P,  1};
        vecs[8]  = '{0, 1, L1,   JUNK, 0, 0, 1, P,  1};
        vecs[9]  = '{1, 0, JUNK, JUNK, 1, 1, 1, P,  1};
        vecs[10] = '{1, 0, JUNK, JUNK, 1, 1, 0, P,  2};

        rst = 1'b1;
        dmx.sel = 1'b0; dmx.in_valid = 1'b0; dmx.inp = '0; dmx.out_ready = 1'b0;
        @(posedge clk);
        #1;
        modelStep(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, vecs[i].sel, vecs[i].inValid, vecs[i].lane0,
                          vecs[i].lane1, vecs[i].outReady);
            checkOutput($sformatf("vec%0d_in_ready", i), {63'd0, dmx.in_ready},
                        {63'd0, vecs[i].expInReady});
            checkOutput($sformatf("vec%0d_out_valid", i), {63'd0, dmx.out_valid},
                        {63'd0, vecs[i].expOutValid});
            checkOutput($sformatf("vec%0d_out_data", i), {14'd0, dmx.out_data},
                        {14'd0, vecs[i].expOutData});
            checkOutput($sformatf("vec%0d_pair_count", i), {56'd0, dmx.pair_count},
                        64'(vecs[i].expCount));
            finishCycle();
        end

        // Backpressure: two pairs stall, third is refused until release
        runCycle(1'b1, 0, 0, '0, '0, 0);
        seen.delete();
        a0 = rndLane(); a1 = rndLane(); b0 = rndLane();
        b1 = rndLane(); c0 = rndLane(); c1 = rndLane();
        runCycle(0, 0, 1, a0, JUNK, 0);
        runCycle(0, 1, 1, JUNK, a1, 0);
        runCycle(0, 0, 0, JUNK, JUNK, 0);
        runCycle(0, 0, 1, b0, JUNK, 0);
        runCycle(0, 1, 1, JUNK, b1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, c0, JUNK, 0);
            checkOutput("bp_in_ready_sel0", {63'd0, dmx.in_ready}, 64'd0);
            checkOutput("bp_hold_data", {14'd0, dmx.out_data}, {14'd0, a1, a0});
            finishCycle();
            applyStimulus(0, 1, 1, JUNK, c1, 0);
            checkOutput("bp_in_ready_sel1", {63'd0, dmx.in_ready}, 64'd0);
            checkOutput("bp_hold_valid", {63'd0, dmx.out_valid}, 64'd1);
            finishCycle();
        end
        cLane[0] = c0;
        cLane[1] = c1;
        for (int s = 0; s < 2; s++) begin
            took = 1'b0;
            for (int t = 0; t < 10 && !took; t++) begin
                applyStimulus(0, s[0], 1, cLane[0], cLane[1], 1);
                took = dmx.in_ready;
                finishCycle();
            end
            checkOutput("bp_release_accept", {63'd0, took}, 64'd1);
        end
        for (int i = 0; i < 4; i++) runCycle(0, 0, 0, JUNK, JUNK, 1);
        checkOutput("bp_pairs_seen", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            checkOutput("bp_order_a", {14'd0, seen[0]}, {14'd0, a1, a0});
            checkOutput("bp_order_b", {14'd0, seen[1]}, {14'd0, b1, b0});
            checkOutput("bp_order_c", {14'd0, seen[2]}, {14'd0, c1, c0});
        end
        checkOutput("bp_pair_count", {56'd0, dmx.pair_count}, 64'd3);

        // Streaming: alternating sel, never stalled, one pair per two cycles
        runCycle(1'b1, 0, 0, '0, '0, 0);
        seen.delete();
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, i[0], 1, rndLane(), rndLane(), 1);
            if (!dmx.in_ready) zeros++;
            finishCycle();
        end
        for (int i = 0; i < 3; i++) runCycle(0, 0, 0, JUNK, JUNK, 1);
        checkOutput("stream_stalls", 64'(zeros), 64'd0);
        checkOutput("stream_pair_count", {56'd0, dmx.pair_count}, 64'd10);

        // Reset in the middle of a pair discards the first half
        runCycle(1'b1, 0, 0, '0, '0, 0);
        runCycle(0, 0, 1, L0, JUNK, 1);
        runCycle(1'b1, 0, 0, JUNK, JUNK, 1);
        runCycle(0, 1, 1, JUNK, L1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, JUNK, JUNK, 1);
            checkOutput("rst_mid_out_valid", {63'd0, dmx.out_valid}, 64'd0);
            finishCycle();
        end
        applyStimulus(0, 1, 0, JUNK, JUNK, 1);
        checkOutput("rst_mid_slot1_full", {63'd0, dmx.in_ready}, 64'd0);
        finishCycle();
        applyStimulus(0, 0, 0, JUNK, JUNK, 1);
        checkOutput("rst_mid_slot0_free", {63'd0, dmx.in_ready}, 64'd1);
        finishCycle();

        // Counter wrap after 256 handshakes
        runCycle(1'b1, 0, 0, '0, '0, 0);
        seen.delete();
        for (int i = 0; i < 512; i++) runCycle(0, i[0], 1, rndLane(), rndLane(), 1);
        for (int i = 0; i < 3; i++) runCycle(0, 0, 0, JUNK, JUNK, 1);
        checkOutput("wrap_handshakes", 64'(seen.size()), 64'd256);
        checkOutput("wrap_pair_count", {56'd0, dmx.pair_count}, 64'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            runCycle($urandom_range(63) == 0, $urandom_range(1) == 1,
                     $urandom_range(3) != 0, rndLane(), rndLane(),
                     $urandom_range(2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
